keypad_scanner: RTL and testbench

Scans the organ's 4x4 key matrix using the 2 kHz scan clock from the divider stage as a rate enable. It drives one row low at a time, samples the column inputs, debounces the result over whole scan frames and reports a single committed key code. The note-generation logic downstream consumes it; everything runs on the system clock.

---
 rtl/organ_pkg.sv | 40 ++++
 rtl/keypad_scanner_if.sv | 28 ++
 rtl/scan_tick_gen.sv | 36 +++
 rtl/keypad_scanner.sv | 131 +++++++++++++
 tb/tb_keypad_scanner.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/organ_pkg.sv
// Shared organ definitions: matrix geometry, key-candidate encoding,
// keypad FSM states and the row-major lowest-index key picker.
package organ_pkg;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int KEY_W = 4;
   localparam int NKEYS = ROWS * COLS;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } kp_state_e;

   // vld=0 marks "no key"; idx is forced to 0 then so that
   // whole-struct compares treat every empty frame alike.
   typedef struct packed {
      logic             vld;
      logic [KEY_W-1:0] idx;
   } key_cand_t;

   localparam key_cand_t NO_KEY = '{vld: 1'b0, idx: '0};

   // frame_n is active-low, bit i = key i (row*COLS + col).
   // Walk high to low so the lowest closed index wins.
   function automatic key_cand_t pick_key(
      input logic [NKEYS-1:0] frame_n
   );
      key_cand_t c;
      c = NO_KEY;
      for (int i = NKEYS - 1; i >= 0; i--) begin
         if (!frame_n[i]) begin
            c.vld = 1'b1;
            c.idx = KEY_W'(i);
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-matrix and key-report bundle of the keypad scanner.
// master: scanner side (reads I_COL, drives rows and key report).
interface keypad_scanner_if;
   import organ_pkg::*;

   logic [COLS-1:0]  I_COL;
   logic [ROWS-1:0]  O_ROW;
   logic [KEY_W-1:0] O_KEY;
   logic             O_VALID;
   logic             O_PRESS;

   modport master (
      input  I_COL,
      output O_ROW,
      output O_KEY,
      output O_VALID,
      output O_PRESS
   );

   modport slave (
      output I_COL,
      input  O_ROW,
      input  O_KEY,
      input  O_VALID,
      input  O_PRESS
   );

endinterface

// File: rtl/scan_tick_gen.sv
// Turns the divider's scan clock into a one-cycle tick on its rising edge.
// Ports: I_CLK, rst (sync, high), I_SCAN_CLK (data) -> tick.
module scan_tick_gen (
   input  logic I_CLK,
   input  logic rst,
   input  logic I_SCAN_CLK,
   output logic tick
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic prev_q, prev_d;

   always_comb begin
      s1_d   = I_SCAN_CLK;
      s2_d   = s1_q;
      prev_d = s2_q;
   end

   // All flops reset to 1: a level already high at reset
   // release must not look like a rising edge.
   always_ff @(posedge I_CLK) begin
      if (rst) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
      end
   end

   assign tick = s2_q & ~prev_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key-matrix scanner: row ring, column sync, frame debounce, key FSM.
// Ports: I_CLK, rst (sync, high), I_SCAN_CLK, kp (master: I_COL in; O_ROW/O_KEY/O_VALID/O_PRESS out).
module keypad_scanner
   import organ_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic              I_CLK,
   input  logic              rst,
   input  logic              I_SCAN_CLK,
   keypad_scanner_if.master  kp
);

   localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

   logic tick;

   scan_tick_gen u_tick (
      .I_CLK      (I_CLK),
      .rst        (rst),
      .I_SCAN_CLK (I_SCAN_CLK),
      .tick       (tick)
   );

   logic [COLS-1:0]  col_s1_q, col_s1_d;
   logic [COLS-1:0]  col_s2_q, col_s2_d;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [ROWS-1:0]  row_q, row_d;
   logic [NKEYS-1:0] frame_q, frame_d;
   key_cand_t        prev_q, prev_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             frame_end;
   key_cand_t        cand;

   kp_state_e        state_q;
   logic [KEY_W-1:0] key_q;
   logic             valid_q;
   logic             press_q;

   always_comb begin
      col_s1_d  = kp.I_COL;
      col_s2_d  = col_s1_q;
      row_idx_d = row_idx_q;
      row_d     = row_q;
      frame_d   = frame_q;
      prev_d    = prev_q;
      cnt_d     = cnt_q;
      frame_end = 1'b0;
      cand      = NO_KEY;
      if (tick) begin
         // Sample the row driven since the previous tick, then move on.
         for (int r = 0; r < ROWS; r++) begin
            if (row_idx_q == 2'(r)) begin
               frame_d[r*COLS +: COLS] = col_s2_q;
            end
         end
         row_idx_d = row_idx_q + 2'd1;
         row_d     = ~(ROWS'(1) << row_idx_d);
         if (row_idx_q == 2'(ROWS - 1)) begin
            frame_end = 1'b1;
            cand      = pick_key(frame_d);
            prev_d    = cand;
            if (cand == prev_q) begin
               cnt_d = (cnt_q >= DB) ? DB : cnt_q + 4'd1;
            end else begin
               cnt_d = 4'd1;
            end
         end
      end
   end

   always_ff @(posedge I_CLK) begin
      if (rst) begin
         col_s1_q  <= '1;
         col_s2_q  <= '1;
         row_idx_q <= 2'd0;
         row_q     <= 4'b1110;
         frame_q   <= '1;
         prev_q    <= NO_KEY;
         cnt_q     <= 4'd0;
      end else begin
         col_s1_q  <= col_s1_d;
         col_s2_q  <= col_s2_d;
         row_idx_q <= row_idx_d;
         row_q     <= row_d;
         frame_q   <= frame_d;
         prev_q    <= prev_d;
         cnt_q     <= cnt_d;
      end
   end

   // Key FSM: acts only at frame end once the candidate is stable.
   always_ff @(posedge I_CLK) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         valid_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         press_q <= 1'b0;
         if (frame_end && cnt_d == DB) begin
            unique case (state_q)
               IDLE: begin
                  if (cand.vld) begin
                     state_q <= HELD;
                     key_q   <= cand.idx;
                     valid_q <= 1'b1;
                     press_q <= 1'b1;
                  end
               end
               HELD: begin
                  if (!cand.vld) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                  end else if (cand.idx != key_q) begin
                     key_q   <= cand.idx;
                     press_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign kp.O_ROW   = row_q;
   assign kp.O_KEY   = key_q;
   assign kp.O_VALID = valid_q;
   assign kp.O_PRESS = press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural key matrix.
// Drives on negedge, checks on negedge well after each processed tick.
module tb_keypad_scanner;
   import organ_pkg::*;

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic        scan = 1'b0;
   logic [15:0] keys = '0;
   logic [3:0]  er;
   logic        drop;
   int          n_chk   = 0;
   int          n_pass  = 0;
   int          presses = 0;

   keypad_scanner_if kif ();

   keypad_scanner #(
      .DEBOUNCE_SCANS (4)
   ) dut (
      .I_CLK      (clk),
      .rst        (rst),
      .I_SCAN_CLK (scan),
      .kp         (kif)
   );

   always #5 clk = ~clk;

   // Matrix: closed key pulls its column low while its row is driven.
   always_comb begin
      kif.I_COL = '1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !kif.O_ROW[r]) begin
               kif.I_COL[c] = 1'b0;
            end
         end
      end
   end

   // Counts cycles with O_PRESS high, so a stretched pulse shows up.
   always @(negedge clk) begin
      if (kif.O_PRESS) presses++;
   end

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(negedge clk) scan = 1'b1;
         repeat (8) @(negedge clk);
         scan = 1'b0;
         repeat (8) @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_row", kif.O_ROW, 4'b1110);
      chk("rst_key", kif.O_KEY, 0);
      chk("rst_valid", kif.O_VALID, 0);
      chk("rst_press", kif.O_PRESS, 0);
      rst = 1'b0;

      // Idle scanning: row ring walks, nothing commits.
      for (int i = 1; i <= 20; i++) begin
         ticks(1);
         er = ~(4'b0001 << (i % 4));
         chk("idle_row", kif.O_ROW, er);
      end
      chk("idle_valid", kif.O_VALID, 0);
      chk("idle_press", presses, 0);

      // Key 6 press and release.
      keys[6] = 1'b1;
      ticks(15);
      chk("k6_early_valid", kif.O_VALID, 0);
      chk("k6_early_press", presses, 0);
      ticks(1);
      chk("k6_valid", kif.O_VALID, 1);
      chk("k6_key", kif.O_KEY, 6);
      chk("k6_press", presses, 1);
      keys = '0;
      ticks(15);
      chk("k6_rel_early", kif.O_VALID, 1);
      ticks(1);
      chk("k6_rel_valid", kif.O_VALID, 0);
      chk("k6_rel_key", kif.O_KEY, 6);
      chk("k6_rel_press", presses, 1);

      // Key 9 with a one-frame gap never reaches 4 stable frames.
      keys[9] = 1'b1;
      ticks(12);
      keys = '0;
      ticks(4);
      keys[9] = 1'b1;
      ticks(12);
      chk("k9_press", presses, 1);
      chk("k9_valid", kif.O_VALID, 0);
      keys = '0;
      ticks(4);

      // Keys 5+13: lowest wins, then roll over to 13.
      keys[5]  = 1'b1;
      keys[13] = 1'b1;
      ticks(16);
      chk("k5_key", kif.O_KEY, 5);
      chk("k5_valid", kif.O_VALID, 1);
      chk("k5_press", presses, 2);
      keys[5] = 1'b0;
      drop = 1'b0;
      for (int i = 0; i < 15; i++) begin
         ticks(1);
         if (!kif.O_VALID) drop = 1'b1;
      end
      chk("roll_early_key", kif.O_KEY, 5);
      ticks(1);
      chk("roll_key", kif.O_KEY, 13);
      chk("roll_valid", kif.O_VALID, 1);
      chk("roll_drop", drop, 0);
      chk("roll_press", presses, 3);

      // Key 3 held, reset mid-frame, recommit.
      keys = '0;
      keys[3] = 1'b1;
      ticks(16);
      chk("k3_key", kif.O_KEY, 3);
      chk("k3_press", presses, 4);
      ticks(2);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk("mrst_valid", kif.O_VALID, 0);
      chk("mrst_key", kif.O_KEY, 0);
      chk("mrst_row", kif.O_ROW, 4'b1110);
      ticks(15);
      chk("k3_re_early", kif.O_VALID, 0);
      ticks(1);
      chk("k3_re_valid", kif.O_VALID, 1);
      chk("k3_re_key", kif.O_KEY, 3);
      chk("k3_re_press", presses, 5);

      // Scan clock high across reset release, then static.
      keys = '0;
      @(negedge clk) scan = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      repeat (1000) @(negedge clk);
      chk("hi_rst_row", kif.O_ROW, 4'b1110);
      scan = 1'b0;
      repeat (20) @(negedge clk);
      chk("fall_row", kif.O_ROW, 4'b1110);
      scan = 1'b1;
      repeat (8) @(negedge clk);
      chk("edge_row", kif.O_ROW, 4'b1101);
      chk("end_press", presses, 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
